add8_err_scan_ctrl: RTL and testbench
=====================================

Name: add8_err_scan_ctrl

Overview:
- Sequencing controller that exhaustively drives an external approximate N-bit adder (8-bit library adders) over every operand pair.
- Compares each approximate result against an internally computed exact sum.
- Accumulates error metrics: sum of absolute errors (→ MAE), worst-case error (WCE) and error count (→ EP).
- Sits in the characterisation harness beside the adder under test; the adder itself stays purely combinational or pipelined outside this block.

Parameters:
- W, 8, operand width of the adder under test; result width W+1.
- DUT_LAT, 0, register stages inside the adder under test (0 = combinational); range 0..7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- abort  in  1  synchronous cancel of a running scan.
- op_a  out  W  operand A to the adder under test (registered).
- op_b  out  W  operand B to the adder under test (registered).
- approx_sum  in  W+1  adder-under-test output O[W:0], valid DUT_LAT cycles after op_a/op_b.
- busy  out  1  high while a scan is in progress (RUN or DRAIN).
- done  out  1  one-cycle pulse when results are final.
- abs_err_sum  out  3W+1  Σ|approx − exact| over all pairs (25 bits at W=8).
- wce  out  W+1  maximum |approx − exact|.
- err_cnt  out  2W+1  number of pairs with approx ≠ exact.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst. rst has priority over all inputs.
- Reset values: state=IDLE, op_a=op_b=0, busy=0, done=0, abs_err_sum=0, wce=0, err_cnt=0, all pipeline valids=0, index=0.
- States: IDLE → RUN → DRAIN → DONE → IDLE.
- IDLE:
  - start=1 at edge 0 clears all accumulators and index, loads op_a=op_b=0 with issue-valid=1, and moves to RUN.
  - Results from the previous scan are held in IDLE until the next accepted start.
- RUN: one pair issued per cycle.
  - 2W-bit index k; op_a=k[2W-1:W], op_b=k[W-1:0].
  - Index k is issued at edge k.
  - After issuing k=2^(2W)−1, the index wraps to 0, issue-valid drops and the state moves to DRAIN.
- Issue-valid pipeline: delayed DUT_LAT stages alongside copies of op_a/op_b. exact = op_a+op_b computed at W+1 bits from the delayed copies.
- Compare stage, at edge k+DUT_LAT+1:
  - register diff = |approx_sum − exact| (W+1 bits, unsigned magnitude);
  - register a mismatch flag;
  - register a valid bit.
- Accumulate stage, at edge k+DUT_LAT+2, when valid:
  - abs_err_sum += diff;
  - err_cnt += mismatch;
  - wce = max(wce, diff).
  - Widths are sized so that no saturation or overflow is possible.
- DRAIN: waits until the compare and accumulate pipelines are empty.
  - The last accumulation occurs at edge 2^(2W)+DUT_LAT+1.
  - On that same edge the state moves to DONE and done is asserted.
  - With W=8 and DUT_LAT=0, done is high in the cycle after edge 65537.
- DONE: done=1 for exactly one cycle, then IDLE. done and busy are never high together.
- busy: high from the cycle after the start edge until DONE is entered.
- start while busy or in DONE: ignored, no effect on the scan.
- abort=1 in RUN or DRAIN:
  - next state IDLE; busy=0, issue and compare valids cleared, no done pulse;
  - accumulators hold their partial values.
- abort in IDLE/DONE: ignored. abort and start in the same IDLE cycle: start wins.
- rst mid-scan: immediate return to reset values, no done.
- approx_sum is sampled only when its delayed valid is set; X on it otherwise is harmless.

Decomposition:
- Shared package add8_scan_pkg:
  - state enum (IDLE, RUN, DRAIN, DONE);
  - width helper constants (RES_W=W+1, CNT_W=2W+1, SUM_W=3W+1).
- One natural sub-module, add8_err_metric_acc:
  - compare stage plus accumulators;
  - inputs: valid, exact, approx, clear;
  - outputs: abs_err_sum, wce, err_cnt.
- The FSM, index counter and DUT_LAT delay line stay in the top.

Test Plan:
- Exact adder stub (approx_sum=op_a+op_b), W=8, DUT_LAT=0, pulse start → done exactly 65537 cycles after the start edge; abs_err_sum=0, wce=0, err_cnt=0.
- Stub forcing O[0]=0 (approx=exact & ~1) → err_cnt=32768, abs_err_sum=32768, wce=1.
- Stub driving approx_sum=0 → abs_err_sum=16711680, wce=510, err_cnt=65535.
- Exact stub with 2-cycle register delay, DUT_LAT=2 → all metrics 0, done after 65539 cycles. Same stub with DUT_LAT=0 → err_cnt>0, which confirms the alignment check.
- Abort at cycle 1000 of RUN → busy falls next cycle, no done, err_cnt holds its partial value; a new start clears it and completes normally.
- start pulsed mid-RUN, and rst asserted at cycle 500 → start has no effect; after rst, all outputs 0 and state IDLE.

Source files
------------

// File: rtl/add8_err_scan_ctrl_pkg.sv
// add8_scan_pkg: shared state encoding and width helpers for the adder error scanner
package add8_scan_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int res_w(input int w);
        return w + 1;
    endfunction

    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    function automatic int sum_w(input int w);
        return 3 * w + 1;
    endfunction

    localparam int DEF_W = 8;
    localparam int RES_W = res_w(DEF_W);
    localparam int CNT_W = cnt_w(DEF_W);
    localparam int SUM_W = sum_w(DEF_W);

endpackage

// File: rtl/add8_err_scan_ctrl_acc.sv
// add8_err_metric_acc: compare stage plus error-metric accumulators
module add8_err_metric_acc
    import add8_scan_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  flush,
    input  logic                  valid,
    input  logic [W:0]            exact,
    input  logic [W:0]            approx,
    output logic [sum_w(W)-1:0]   abs_err_sum,
    output logic [res_w(W)-1:0]   wce,
    output logic [cnt_w(W)-1:0]   err_cnt
);

    localparam int SW = sum_w(W);
    localparam int CW = cnt_w(W);

    logic [W:0] diff_c;
    logic [W:0] diff;
    logic       mis;
    logic       cv;

    assign diff_c = approx >= exact ? approx - exact : exact - approx;

    // Compare stage: approx is only looked at when its pair is valid
    always_ff @(posedge clk) begin
        if (rst || clear || flush) begin
            cv   <= 1'b0;
            diff <= '0;
            mis  <= 1'b0;
        end else begin
            cv   <= valid;
            diff <= valid ? diff_c : '0;
            mis  <= valid && (approx != exact);
        end
    end

    // Accumulate stage: frozen on abort so partial results stay visible
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            abs_err_sum <= '0;
            wce         <= '0;
            err_cnt     <= '0;
        end else if (cv && !flush) begin
            abs_err_sum <= abs_err_sum + SW'(diff);
            err_cnt     <= err_cnt + CW'(mis);
            wce         <= diff > wce ? diff : wce;
        end
    end

endmodule

// File: rtl/add8_err_scan_ctrl.sv
// add8_err_scan_ctrl: exhaustive operand sequencer and error-metric collector for an external adder
module add8_err_scan_ctrl
    import add8_scan_pkg::*;
#(
    parameter int W       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [W-1:0]          op_a,
    output logic [W-1:0]          op_b,
    input  logic [W:0]            approx_sum,
    output logic                  busy,
    output logic                  done,
    output logic [sum_w(W)-1:0]   abs_err_sum,
    output logic [res_w(W)-1:0]   wce,
    output logic [cnt_w(W)-1:0]   err_cnt
);

    localparam logic [2*W-1:0] K_PEN = {{(2*W-1){1'b1}}, 1'b0};

    state_t         state, state_n;
    logic [2*W-1:0] k, k_n;
    logic           iv, iv_n;
    logic           clear;
    logic           kill;
    logic           vd;
    logic           pend;
    logic [W-1:0]   ad, bd;

    assign {op_a, op_b} = k;
    assign busy = state == RUN || state == DRAIN;
    assign done = state == DONE;
    assign kill = busy && abort;

    // State, index and issue-valid registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
            iv    <= 1'b0;
        end else begin
            state <= state_n;
            k     <= k_n;
            iv    <= iv_n;
        end
    end

    // Next state: the last pair is loaded on the edge that leaves RUN
    always_comb begin
        state_n = state;
        k_n     = k;
        iv_n    = 1'b0;
        clear   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = RUN;
                k_n     = '0;
                iv_n    = 1'b1;
                clear   = 1'b1;
            end
            RUN: if (abort) begin
                state_n = IDLE;
            end else begin
                iv_n    = 1'b1;
                k_n     = k + 1'b1;
                state_n = k == K_PEN ? DRAIN : RUN;
            end
            DRAIN: begin
                k_n     = '0;
                state_n = abort ? IDLE : (pend ? DRAIN : DONE);
            end
            default: state_n = IDLE;
        endcase
    end

    generate
        if (DUT_LAT == 0) begin : g_nodly
            assign vd   = iv;
            assign ad   = op_a;
            assign bd   = op_b;
            assign pend = iv;
        end else begin : g_dly
            logic [DUT_LAT-1:0] vp;
            logic [W-1:0]       ap [DUT_LAT];
            logic [W-1:0]       bp [DUT_LAT];
            // Valid delay line matching the adder latency; emptied on abort
            always_ff @(posedge clk) begin
                if (rst || kill) begin
                    vp <= '0;
                end else begin
                    vp[0] <= iv;
                    for (int i = 1; i < DUT_LAT; i++) vp[i] <= vp[i-1];
                end
            end
            // Operand copies travel alongside their valid bits
            always_ff @(posedge clk) begin
                ap[0] <= op_a;
                bp[0] <= op_b;
                for (int i = 1; i < DUT_LAT; i++) begin
                    ap[i] <= ap[i-1];
                    bp[i] <= bp[i-1];
                end
            end
            assign vd   = vp[DUT_LAT-1];
            assign ad   = ap[DUT_LAT-1];
            assign bd   = bp[DUT_LAT-1];
            assign pend = iv | (|vp);
        end
    endgenerate

    add8_err_metric_acc #(.W(W)) u_acc (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .flush       (kill),
        .valid       (vd),
        .exact       ({1'b0, ad} + {1'b0, bd}),
        .approx      (approx_sum),
        .abs_err_sum (abs_err_sum),
        .wce         (wce),
        .err_cnt     (err_cnt)
    );

endmodule

// File: tb/tb_add8_err_scan_ctrl.sv
// tb_add8_err_scan_ctrl: scoreboard bench for the adder error scanner at W=8 and W=4
module tb_add8_err_scan_ctrl;

    typedef struct {
        longint sum;
        int     wce;
        int     cnt;
        int     lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_s = 1'b0;
    logic abort_s = 1'b0;
    int   sel = 0;
    int   mode8 = 0, mode4 = 0, mode4d = 0;
    int   errors = 0, checks = 0;
    bit   overlap = 1'b0;
    exp_t q[$];

    logic [7:0]  op_a8, op_b8;
    logic [8:0]  ap8;
    logic        busy8, done8;
    logic [24:0] sum8;
    logic [8:0]  wce8;
    logic [16:0] cnt8;

    logic [3:0]  op_a4, op_b4, op_a4d, op_b4d;
    logic [4:0]  ap4, ap4d, r4a, r4b, r4da, r4db;
    logic        busy4, done4, busy4d, done4d;
    logic [12:0] sum4, sum4d;
    logic [4:0]  wce4, wce4d;
    logic [8:0]  cnt4, cnt4d;

    logic   busy_s, done_s;
    longint sum_s;
    int     wce_s, cnt_s;

    always #5 clk = ~clk;

    add8_err_scan_ctrl #(.W(8), .DUT_LAT(0)) u8 (
        .clk(clk), .rst(rst), .start(start_s && sel == 0), .abort(abort_s && sel == 0),
        .op_a(op_a8), .op_b(op_b8), .approx_sum(ap8), .busy(busy8), .done(done8),
        .abs_err_sum(sum8), .wce(wce8), .err_cnt(cnt8));

    add8_err_scan_ctrl #(.W(4), .DUT_LAT(0)) u4 (
        .clk(clk), .rst(rst), .start(start_s && sel == 1), .abort(abort_s && sel == 1),
        .op_a(op_a4), .op_b(op_b4), .approx_sum(ap4), .busy(busy4), .done(done4),
        .abs_err_sum(sum4), .wce(wce4), .err_cnt(cnt4));

    add8_err_scan_ctrl #(.W(4), .DUT_LAT(2)) u4d (
        .clk(clk), .rst(rst), .start(start_s && sel == 2), .abort(abort_s && sel == 2),
        .op_a(op_a4d), .op_b(op_b4d), .approx_sum(ap4d), .busy(busy4d), .done(done4d),
        .abs_err_sum(sum4d), .wce(wce4d), .err_cnt(cnt4d));

    // Adder stubs: 0 exact, 1 LSB forced low, 2 constant zero, 3 exact with two register stages
    always @(posedge clk) begin
        r4a  <= {1'b0, op_a4} + {1'b0, op_b4};
        r4b  <= r4a;
        r4da <= {1'b0, op_a4d} + {1'b0, op_b4d};
        r4db <= r4da;
    end

    function automatic logic [8:0] stub8(input int m, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return m == 1 ? s & 9'h1FE : m == 2 ? 9'd0 : s;
    endfunction

    function automatic logic [4:0] stub4(input int m, input logic [3:0] a, input logic [3:0] b, input logic [4:0] d);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
        return m == 1 ? s & 5'h1E : m == 2 ? 5'd0 : m == 3 ? d : s;
    endfunction

    assign ap8  = stub8(mode8, op_a8, op_b8);
    assign ap4  = stub4(mode4, op_a4, op_b4, r4b);
    assign ap4d = stub4(mode4d, op_a4d, op_b4d, r4db);

    always_comb begin
        busy_s = sel == 0 ? busy8 : sel == 1 ? busy4 : busy4d;
        done_s = sel == 0 ? done8 : sel == 1 ? done4 : done4d;
        sum_s  = sel == 0 ? longint'(sum8) : sel == 1 ? longint'(sum4) : longint'(sum4d);
        wce_s  = sel == 0 ? int'(wce8) : sel == 1 ? int'(wce4) : int'(wce4d);
        cnt_s  = sel == 0 ? int'(cnt8) : sel == 1 ? int'(cnt4) : int'(cnt4d);
    end

    always @(negedge clk) if (busy_s && done_s) overlap = 1'b1;

    // Reference metrics over the first n pairs of a w-bit scan
    task automatic model(input int w, input int m, input int n, output longint s, output int wc, output int c);
        int a, b, ex, apx, d;
        s = 0; wc = 0; c = 0;
        for (int k = 0; k < n; k++) begin
            a = k >> w;
            b = k & ((1 << w) - 1);
            ex = a + b;
            apx = m == 1 ? (ex & ~1) : m == 2 ? 0 : ex;
            d = apx > ex ? apx - ex : ex - apx;
            s += d;
            c += (d != 0) ? 1 : 0;
            if (d > wc) wc = d;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input int s, input int m);
        if (s == 0) mode8 = m;
        else if (s == 1) mode4 = m;
        else mode4d = m;
    endtask

    task automatic kick();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
    endtask

    task automatic wait_done(output int n, output bit ok);
        n = 0;
        ok = 1'b0;
        while (n < 70000 && !ok) begin
            tick();
            n++;
            ok = done_s;
        end
    endtask

    task automatic check_result(input string nm, input int n, input bit ok);
        exp_t e;
        e = q.pop_front();
        checks++; if (!ok) begin errors++; $display("FAIL %s done_timeout got=0 want=1", nm); end
        checks++; if (n !== e.lat) begin errors++; $display("FAIL %s latency got=%0d want=%0d", nm, n, e.lat); end
        checks++; if (sum_s !== e.sum) begin errors++; $display("FAIL %s abs_err_sum got=%0d want=%0d", nm, sum_s, e.sum); end
        checks++; if (wce_s !== e.wce) begin errors++; $display("FAIL %s wce got=%0d want=%0d", nm, wce_s, e.wce); end
        checks++; if (cnt_s !== e.cnt) begin errors++; $display("FAIL %s err_cnt got=%0d want=%0d", nm, cnt_s, e.cnt); end
        tick();
        checks++; if (done_s !== 1'b0 || busy_s !== 1'b0) begin errors++; $display("FAIL %s after_done got=%0b%0b want=00", nm, done_s, busy_s); end
        repeat (3) tick();
        checks++; if (cnt_s !== e.cnt || sum_s !== e.sum) begin errors++; $display("FAIL %s hold got=%0d want=%0d", nm, cnt_s, e.cnt); end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL %s busy_done_overlap got=1 want=0", nm); end
    endtask

    task automatic run_scan(input string nm, input int s, input int stub, input int mm, input int w, input int lat);
        exp_t e;
        int   n;
        bit   ok;
        sel = s;
        set_mode(s, stub);
        overlap = 1'b0;
        model(w, mm, 1 << (2 * w), e.sum, e.wce, e.cnt);
        e.lat = (1 << (2 * w)) + lat + 1;
        q.push_back(e);
        kick();
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%0b want=1", nm, busy_s); end
        wait_done(n, ok);
        check_result(nm, n, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        checks++; if ({busy8, done8} !== 2'b00) begin errors++; $display("FAIL reset_flags8 got=%0b%0b want=00", busy8, done8); end
        checks++; if ({op_a8, op_b8} !== 16'h0) begin errors++; $display("FAIL reset_ops8 got=%h want=0", {op_a8, op_b8}); end
        checks++; if (sum8 !== 25'd0 || wce8 !== 9'd0 || cnt8 !== 17'd0) begin errors++; $display("FAIL reset_metrics8 got=%0d/%0d/%0d want=0/0/0", sum8, wce8, cnt8); end
        checks++; if ({busy4d, done4d} !== 2'b00) begin errors++; $display("FAIL reset_flags4d got=%0b%0b want=00", busy4d, done4d); end
        checks++; if (sum4d !== 13'd0 || cnt4d !== 9'd0) begin errors++; $display("FAIL reset_metrics4d got=%0d/%0d want=0/0", sum4d, cnt4d); end
    endtask

    task automatic test_lsb_w8();
        run_scan("lsb_w8", 0, 1, 1, 8, 0);
    endtask

    task automatic test_patterns_w4();
        run_scan("exact_w4", 1, 0, 0, 4, 0);
        run_scan("zero_w4", 1, 2, 2, 4, 0);
        run_scan("lsb_w4", 1, 1, 1, 4, 0);
    endtask

    task automatic test_latency();
        int n;
        bit ok;
        run_scan("lat2_aligned", 2, 3, 0, 4, 2);
        sel = 1;
        set_mode(1, 3);
        kick();
        wait_done(n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL misaligned done_timeout got=0 want=1"); end
        checks++; if (cnt4 == 9'd0) begin errors++; $display("FAIL misaligned err_cnt got=0 want=>0"); end
        repeat (2) tick();
    endtask

    task automatic test_abort();
        exp_t e;
        sel = 1;
        set_mode(1, 1);
        model(4, 1, 98, e.sum, e.wce, e.cnt);
        kick();
        repeat (99) tick();
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%0b want=0", busy4); end
        overlap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done4) overlap = 1'b1;
            tick();
        end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL abort_no_done got=1 want=0"); end
        checks++; if (int'(cnt4) !== e.cnt) begin errors++; $display("FAIL abort_partial_cnt got=%0d want=%0d", cnt4, e.cnt); end
        checks++; if (longint'(sum4) !== e.sum) begin errors++; $display("FAIL abort_partial_sum got=%0d want=%0d", sum4, e.sum); end
        abort_s = 1'b1;
        tick();
        abort_s = 1'b0;
        checks++; if (int'(cnt4) !== e.cnt || busy4 !== 1'b0) begin errors++; $display("FAIL abort_idle_ignored got=%0d want=%0d", cnt4, e.cnt); end
        run_scan("after_abort", 1, 1, 1, 4, 0);
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   n;
        bit   ok;
        sel = 1;
        set_mode(1, 2);
        overlap = 1'b0;
        model(4, 2, 256, e.sum, e.wce, e.cnt);
        e.lat = 257;
        q.push_back(e);
        start_s = 1'b1;
        abort_s = 1'b1;
        tick();
        start_s = 1'b0;
        abort_s = 1'b0;
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL start_beats_abort got=%0b want=1", busy4); end
        repeat (49) tick();
        kick();
        wait_done(n, ok);
        check_result("start_mid_run", n + 50, ok);
    endtask

    task automatic test_rst_mid();
        sel = 1;
        set_mode(1, 2);
        kick();
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy4, done4} !== 2'b00) begin errors++; $display("FAIL rst_mid_flags got=%0b%0b want=00", busy4, done4); end
        checks++; if (sum4 !== 13'd0 || wce4 !== 5'd0 || cnt4 !== 9'd0) begin errors++; $display("FAIL rst_mid_metrics got=%0d/%0d/%0d want=0/0/0", sum4, wce4, cnt4); end
        checks++; if ({op_a4, op_b4} !== 8'h0) begin errors++; $display("FAIL rst_mid_ops got=%h want=0", {op_a4, op_b4}); end
        overlap = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (done4 || busy4) overlap = 1'b1;
            tick();
        end
        checks++; if (overlap !== 1'b0) begin errors++; $display("FAIL rst_mid_idle got=1 want=0"); end
    endtask

    initial begin
        test_reset();
        test_lsb_w8();
        test_patterns_w4();
        test_latency();
        test_abort();
        test_start_ignored();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
